osc_monitor: RTL and testbench

- Consumer side of the on-chip oscillator interface. Drives the oscillator enable and watches the returned (divided) oscillator output.
- Sequences oscillator start-up, then measures the oscillator continuously by counting rising edges over a fixed window of the always-on system clock.
- Flags the oscillator ready or faulty for the I2C core and system control logic.

---
 rtl/osc_monitor_pkg.sv | 23 ++
 rtl/osc_edge_sync.sv | 32 +++
 rtl/osc_monitor.sv | 140 ++++++++++++++
 tb/tb_osc_monitor.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osc_monitor_pkg.sv
// Shared types and default constants for the oscillator monitor.
// The window and threshold defaults are also reused by the I2C clock-divider config.
package osc_monitor_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WARMUP  = 2'd1,
      MEASURE = 2'd2,
      EVAL    = 2'd3
   } osc_state_t;

   localparam int DEF_REF_WINDOW     = 1024;
   localparam int DEF_STARTUP_CYCLES = 256;
   localparam int DEF_CNT_W          = 16;
   localparam int DEF_MIN_EDGES      = 112;
   localparam int DEF_MAX_EDGES      = 144;
   localparam int DEF_SYNC_STAGES    = 2;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/osc_edge_sync.sv
// Synchronizes the asynchronous oscillator output into clk and flags its rising edges.
// clear holds the edge history at 0 so the first sample after clear=0 can count as an edge.
module osc_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic osc_in,
   input  logic clear,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_out;
   logic                   prev;

   assign sync_out = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_q <= '0;
         prev   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make the chain shift exactly one stage per clock.
         sync_q <= {sync_q[SYNC_STAGES-2:0], osc_in};
         prev   <= clear ? 1'b0 : sync_out;
      end
   end

   assign rise = sync_out & ~prev;

endmodule

// File: rtl/osc_monitor.sv
// Oscillator consumer: sequences enable and start-up, then counts oscillator edges per
// reference window of clk and reports ready/fault status.
module osc_monitor
   import osc_monitor_pkg::*;
#(
   parameter int REF_WINDOW     = DEF_REF_WINDOW,
   parameter int STARTUP_CYCLES = DEF_STARTUP_CYCLES,
   parameter int CNT_W          = DEF_CNT_W,
   parameter int MIN_EDGES      = DEF_MIN_EDGES,
   parameter int MAX_EDGES      = DEF_MAX_EDGES,
   parameter int SYNC_STAGES    = DEF_SYNC_STAGES
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             enable_req,
   input  logic             osc_in,
   output logic             oscen,
   output logic             osc_ready,
   output logic             osc_fault,
   output logic [CNT_W-1:0] edge_count,
   output logic             count_valid,
   output logic             busy
);

   localparam int               TMR_W     = $clog2(max_int(REF_WINDOW, STARTUP_CYCLES));
   localparam logic [TMR_W-1:0] WARM_LAST = TMR_W'(STARTUP_CYCLES - 1);
   localparam logic [TMR_W-1:0] WIN_LAST  = TMR_W'(REF_WINDOW - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] MIN_CNT   = CNT_W'(MIN_EDGES);
   localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_EDGES);

   if (REF_WINDOW < 2 || STARTUP_CYCLES < 1 || SYNC_STAGES < 2) begin : g_bad_timing
      $error("osc_monitor: needs REF_WINDOW>=2, STARTUP_CYCLES>=1, SYNC_STAGES>=2");
   end
   if (MIN_EDGES < 0 || MIN_EDGES > MAX_EDGES ||
       longint'(MAX_EDGES) >= (longint'(1) << CNT_W)) begin : g_bad_limits
      $error("osc_monitor: needs 0 <= MIN_EDGES <= MAX_EDGES < 2**CNT_W");
   end

   osc_state_t       state, state_d;
   logic [TMR_W-1:0] timer, timer_d;
   logic [CNT_W-1:0] cnt, cnt_d, edge_count_d;
   logic             ready_d, fault_d, valid_d;
   logic             rise, in_range;

   osc_edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_edge_sync (
      .clk   (clk),
      .rstn  (rstn),
      .osc_in(osc_in),
      .clear (state == IDLE),
      .rise  (rise)
   );

   assign in_range = (cnt >= MIN_CNT) && (cnt <= MAX_CNT);
   assign oscen    = (state != IDLE);
   assign busy     = (state != IDLE);

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path infers a latch.
      state_d      = state;
      timer_d      = timer;
      cnt_d        = cnt;
      edge_count_d = edge_count;
      ready_d      = osc_ready;
      fault_d      = osc_fault;
      valid_d      = 1'b0;
      case (state)
         IDLE: begin
            timer_d = '0;
            cnt_d   = '0;
            if (enable_req) begin
               state_d = WARMUP;
               ready_d = 1'b0;
               fault_d = 1'b0;
            end
         end
         WARMUP: begin
            if (!enable_req) begin
               state_d = IDLE;
               ready_d = 1'b0;
               timer_d = '0;
            end else if (timer == WARM_LAST) begin
               state_d = MEASURE;
               timer_d = '0;
            end else begin
               timer_d = timer + 1'b1;
            end
         end
         MEASURE: begin
            if (!enable_req) begin
               state_d = IDLE;
               ready_d = 1'b0;
               timer_d = '0;
               cnt_d   = '0;
            end else begin
               if (rise && cnt != CNT_MAX) cnt_d = cnt + 1'b1;
               if (timer == WIN_LAST) begin
                  state_d = EVAL;
                  timer_d = '0;
               end else begin
                  timer_d = timer + 1'b1;
               end
            end
         end
         EVAL: begin
            // Edges seen in this cycle are dropped along with the cleared counter.
            edge_count_d = cnt;
            valid_d      = 1'b1;
            ready_d      = in_range;
            if (!in_range) fault_d = 1'b1;
            cnt_d        = '0;
            state_d      = enable_req ? MEASURE : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         timer       <= '0;
         cnt         <= '0;
         edge_count  <= '0;
         osc_ready   <= 1'b0;
         osc_fault   <= 1'b0;
         count_valid <= 1'b0;
      end else begin
         state       <= state_d;
         timer       <= timer_d;
         cnt         <= cnt_d;
         edge_count  <= edge_count_d;
         osc_ready   <= ready_d;
         osc_fault   <= fault_d;
         count_valid <= valid_d;
      end
   end

endmodule

// File: tb/tb_osc_monitor.sv
// Self-checking bench for osc_monitor: table of oscillator patterns with expected results,
// hand-written timing/abort/reset sequences, and random patterns against an edge-count model.
module tb_osc_monitor;

   localparam int OSC_STUCK    = 0;
   localparam int OSC_PERIODIC = 1;
   localparam int OSC_BURST    = 2;
   localparam int OSC_RANDOM   = 3;
   localparam int BURST_START  = 300;
   localparam int HIST_N       = 65536;

   logic        clk;
   logic        rstn;
   logic        enable_req;
   logic        osc_in;
   logic        oscen, osc_ready, osc_fault, count_valid, busy;
   logic [15:0] edge_count;
   logic        sat_oscen, sat_ready, sat_fault, sat_valid, sat_busy;
   logic [3:0]  sat_count;

   int vectors     = 0;
   int miscompares = 0;

   int osc_mode = OSC_STUCK;
   int osc_arg  = 0;
   int osc_cfg  = 0;
   int osc_lo   = 1;
   int osc_hi   = 3;

   bit hist [0:HIST_N-1];
   int cyc = 0;

   osc_monitor dut (
      .clk        (clk),
      .rstn       (rstn),
      .enable_req (enable_req),
      .osc_in     (osc_in),
      .oscen      (oscen),
      .osc_ready  (osc_ready),
      .osc_fault  (osc_fault),
      .edge_count (edge_count),
      .count_valid(count_valid),
      .busy       (busy)
   );

   osc_monitor #(
      .CNT_W    (4),
      .MIN_EDGES(1),
      .MAX_EDGES(14)
   ) dut_sat (
      .clk        (clk),
      .rstn       (rstn),
      .enable_req (enable_req),
      .osc_in     (osc_in),
      .oscen      (sat_oscen),
      .osc_ready  (sat_ready),
      .osc_fault  (sat_fault),
      .edge_count (sat_count),
      .count_valid(sat_valid),
      .busy       (sat_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Record osc_in as seen at each clk edge, for the reference model.
   always @(posedge clk) begin
      if (cyc < HIST_N) hist[cyc] <= osc_in;
      cyc <= cyc + 1;
   end

   // Oscillator pattern generator; restarts its phase whenever the configuration changes.
   initial begin : osc_drv
      int ph;
      int seen;
      int hold;
      ph   = 0;
      seen = 0;
      hold = 0;
      osc_in = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (seen != osc_cfg) begin
            seen = osc_cfg;
            ph   = 0;
            hold = 0;
         end
         case (osc_mode)
            OSC_STUCK:    osc_in = 1'b0;
            OSC_PERIODIC: osc_in = ((ph / osc_arg) % 2) == 1;
            OSC_BURST:    osc_in = (ph >= BURST_START) && ((ph - BURST_START) / 6 < osc_arg) &&
                                   ((ph - BURST_START) % 6 >= 3);
            default: begin
               if (hold == 0) begin
                  osc_in = ~osc_in;
                  hold   = $urandom_range(osc_hi, osc_lo);
               end else begin
                  hold--;
               end
            end
         endcase
         ph++;
      end
   end

   // Rising edges of osc_in that land in the REF_WINDOW cycles starting at clk edge 'first',
   // as seen through the two-flop synchronizer, saturated at sat_max.
   function automatic int model_count(input int first, input int sat_max);
      int n;
      n = 0;
      for (int m = first; m < first + 1024; m++)
         if (hist[m-1] && !hist[m-2]) n++;
      return (n > sat_max) ? sat_max : n;
   endfunction

   task automatic check(input string name, input longint actual, input longint expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic set_osc(input int mode, input int arg);
      osc_mode = mode;
      osc_arg  = arg;
      osc_cfg++;
   endtask

   task automatic wait_valid(output int v_edge);
      v_edge = -1;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1;
         if (count_valid) begin
            v_edge = cyc - 1;
            return;
         end
      end
      vectors++;
      miscompares++;
      $display("FAIL count_valid_timeout: no pulse within 3000 cycles");
   endtask

   // Returns to IDLE, loads a new pattern and raises enable_req; e0 is the sampling edge.
   task automatic restart(input int mode, input int arg, output int e0);
      @(negedge clk);
      enable_req = 1'b0;
      repeat (3) @(negedge clk);
      set_osc(mode, arg);
      enable_req = 1'b1;
      @(posedge clk);
      #1;
      e0 = cyc - 1;
   endtask

   typedef struct {
      int mode;
      int arg;
      int exp_count;
      bit exp_ready;
      bit exp_fault;
   } vec_t;

   vec_t vecs [8];

   initial begin : main
      int e0, v, v2, seen_valid, cnt;
      bit in_range, fault_exp;

      vecs[0] = '{OSC_PERIODIC, 4,   128, 1'b1, 1'b0};
      vecs[1] = '{OSC_STUCK,    0,     0, 1'b0, 1'b1};
      vecs[2] = '{OSC_PERIODIC, 2,   256, 1'b0, 1'b1};
      vecs[3] = '{OSC_PERIODIC, 8,    64, 1'b0, 1'b1};
      vecs[4] = '{OSC_BURST,    112, 112, 1'b1, 1'b0};
      vecs[5] = '{OSC_BURST,    111, 111, 1'b0, 1'b1};
      vecs[6] = '{OSC_BURST,    144, 144, 1'b1, 1'b0};
      vecs[7] = '{OSC_BURST,    145, 145, 1'b0, 1'b1};

      rstn       = 1'b0;
      enable_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_oscen", oscen, 0);
      check("reset_busy", busy, 0);
      check("reset_edge_count", edge_count, 0);
      check("reset_count_valid", count_valid, 0);
      @(negedge clk);
      rstn = 1'b1;
      repeat (2) @(negedge clk);

      // Nominal start-up timing and repetition rate.
      set_osc(OSC_PERIODIC, 4);
      enable_req = 1'b1;
      check("idle_oscen_before_sample", oscen, 0);
      @(posedge clk);
      #1;
      e0 = cyc - 1;
      check("oscen_after_sample", oscen, 1);
      check("busy_after_sample", busy, 1);
      wait_valid(v);
      check("first_valid_latency", v - e0, 1281);
      check("nominal_count", edge_count, 128);
      check("nominal_ready", osc_ready, 1);
      check("nominal_fault", osc_fault, 0);
      @(posedge clk);
      #1;
      check("valid_one_cycle", count_valid, 0);
      wait_valid(v2);
      check("valid_period", v2 - v, 1025);
      check("nominal_count_2", edge_count, 128);

      // Abort 500 cycles into MEASURE.
      repeat (500) @(negedge clk);
      enable_req = 1'b0;
      @(posedge clk);
      #1;
      check("abort_busy", busy, 0);
      check("abort_oscen", oscen, 0);
      check("abort_ready", osc_ready, 0);
      check("abort_valid", count_valid, 0);
      check("abort_keeps_count", edge_count, 128);
      check("abort_keeps_fault", osc_fault, 0);
      seen_valid = 0;
      repeat (1400) begin
         @(posedge clk);
         #1;
         if (count_valid) seen_valid++;
      end
      check("abort_no_valid", seen_valid, 0);

      // Pattern table: each row restarts from IDLE so osc_fault starts clear.
      for (int i = 0; i < 8; i++) begin
         restart(vecs[i].mode, vecs[i].arg, e0);
         wait_valid(v);
         check($sformatf("row%0d_count", i), edge_count, vecs[i].exp_count);
         check($sformatf("row%0d_ready", i), osc_ready, vecs[i].exp_ready);
         check($sformatf("row%0d_fault", i), osc_fault, vecs[i].exp_fault);
      end

      // Too fast, plus saturation in the 4-bit instance, then re-enable clears the fault.
      restart(OSC_PERIODIC, 2, e0);
      wait_valid(v);
      check("fast_count", edge_count, 256);
      check("fast_fault", osc_fault, 1);
      check("sat_count", sat_count, 15);
      check("sat_fault", sat_fault, 1);
      check("sat_ready", sat_ready, 0);
      @(negedge clk);
      enable_req = 1'b0;
      @(posedge clk);
      #1;
      check("fast_idle_keeps_fault", osc_fault, 1);
      check("fast_idle_busy", busy, 0);
      @(negedge clk);
      enable_req = 1'b1;
      @(posedge clk);
      #1;
      check("reenable_clears_fault", osc_fault, 0);
      check("reenable_oscen", oscen, 1);

      // Random oscillator against the edge-count model; starts while in WARMUP.
      set_osc(OSC_RANDOM, 0);
      fault_exp = 1'b0;
      for (int w = 0; w < 6; w++) begin
         wait_valid(v);
         if (v < 0) break;
         cnt      = model_count(v - 1025, 65535);
         in_range = (cnt >= 112) && (cnt <= 144);
         fault_exp |= !in_range;
         check($sformatf("rand%0d_count", w), edge_count, cnt);
         check($sformatf("rand%0d_ready", w), osc_ready, in_range);
         check($sformatf("rand%0d_fault", w), osc_fault, fault_exp);
         check($sformatf("rand%0d_sat_count", w), sat_count, model_count(v - 1025, 15));
         osc_lo = $urandom_range(3, 1);
         osc_hi = osc_lo + $urandom_range(3, 0);
      end

      // Async reset in the middle of a measurement.
      set_osc(OSC_PERIODIC, 4);
      wait_valid(v);
      wait_valid(v);
      check("pre_reset_ready", osc_ready, 1);
      repeat (200) @(posedge clk);
      #3;
      rstn = 1'b0;
      #1;
      check("async_reset_oscen", oscen, 0);
      check("async_reset_busy", busy, 0);
      check("async_reset_ready", osc_ready, 0);
      check("async_reset_fault", osc_fault, 0);
      check("async_reset_valid", count_valid, 0);
      check("async_reset_count", edge_count, 0);
      @(negedge clk);
      enable_req = 1'b0;
      rstn       = 1'b1;
      @(posedge clk);
      #1;
      check("post_reset_idle", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
